// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if
//   Bundles the two writeback requesters (A = ALU, B = load/MEM), the decode
//   hazard-check signals and the register-file write port.
//   master : requester / decode side (drives requests, reads ready/stall/write)
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface writeback_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // Requester A (ALU)
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   // Requester B (load/MEM)
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   // Decode issue / hazard check
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] inst_read_reg_addr1;
   logic [ADDR_W-1:0] inst_read_reg_addr2;
   logic              stall;
   // Register-file write port
   logic              reg_wr;
   logic [ADDR_W-1:0] reg_wr_addr;
   logic [DATA_W-1:0] reg_wr_data;

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      output issue_valid, issue_addr, inst_read_reg_addr1, inst_read_reg_addr2,
      input  a_ready, b_ready, stall,
      input  reg_wr, reg_wr_addr, reg_wr_data
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      input  issue_valid, issue_addr, inst_read_reg_addr1, inst_read_reg_addr2,
      output a_ready, b_ready, stall,
      output reg_wr, reg_wr_addr, reg_wr_data
   );
endinterface

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
//   Shares the register file's single write port between the ALU (port A) and
//   the load unit (port B) with round-robin arbitration, and keeps a per-
//   register busy scoreboard that decode uses to hold RAW/WAW hazards.
//
// Ports
//   clk    : system clock, all state on posedge
//   reset  : asynchronous, active-high reset
//   wb     : writeback_arbiter_if.slave
//              a_* / b_*          requester handshakes (ready = granted now)
//              issue_*, inst_*    decode issue and source registers
//              stall              decode must hold (combinational)
//              reg_wr*            registered register-file write port
// ----------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   writeback_arbiter_if.slave   wb
);

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Round-robin pointer: the port that won most recently
   logic              rr_last_q, rr_last_d;

   // Registered write port
   logic              reg_wr_q,   reg_wr_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,  wr_data_d;

   // Busy scoreboard; register 0 has no storage and always reads not-busy
   logic [NUM_REGS-1:1] busy_q, busy_d;
   logic [NUM_REGS-1:0] busy_vec;

   logic              grant_a, grant_b, grant_any;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              stall_c;
   logic              set_en;

   assign busy_vec = {busy_q, 1'b0};

   // ---------------------------------------------------------------- grant
   // On a tie the port that did not win last time gets the slot.
   always_comb begin
      grant_a   = wb.a_valid & (~wb.b_valid | (rr_last_q == PORT_B));
      grant_b   = wb.b_valid & (~wb.a_valid | (rr_last_q == PORT_A));
      grant_any = grant_a | grant_b;
      win_addr  = grant_a ? wb.a_addr : wb.b_addr;
      win_data  = grant_a ? wb.a_data : wb.b_data;

      rr_last_d = rr_last_q;
      if (grant_a)      rr_last_d = PORT_A;
      else if (grant_b) rr_last_d = PORT_B;

      // r0 writes are accepted but never reach the register file
      reg_wr_d  = grant_any & (win_addr != '0);
      wr_addr_d = grant_any ? win_addr : wr_addr_q;
      wr_data_d = grant_any ? win_data : wr_data_q;
   end

   // ---------------------------------------------------------------- hazard
   always_comb begin
      stall_c = busy_vec[wb.inst_read_reg_addr1]
              | busy_vec[wb.inst_read_reg_addr2]
              | (wb.issue_valid & busy_vec[wb.issue_addr]);
      // A stalled issue must not mark its destination busy
      set_en  = wb.issue_valid & ~stall_c & (wb.issue_addr != '0);
   end

   // Per-register next state: a new issue to the same register outranks a
   // completing write, since the newer producer is still outstanding.
   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
         logic set_hit, clr_hit;
         assign set_hit    = set_en   & (wb.issue_addr == ADDR_W'(gi));
         assign clr_hit    = reg_wr_d & (win_addr      == ADDR_W'(gi));
         assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
      end
   endgenerate

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last_q <= PORT_B;   // A wins the first tie after reset
         reg_wr_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         reg_wr_q  <= reg_wr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign wb.a_ready     = grant_a;
   assign wb.b_ready     = grant_b;
   assign wb.stall       = stall_c;
   assign wb.reg_wr      = reg_wr_q;
   assign wb.reg_wr_addr = wr_addr_q;
   assign wb.reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (busy bit array, last-winner flag) predicts ready/stall each cycle and
//   pushes expected register-file writes into a queue; a separate monitor
//   pops and compares whenever reg_wr is asserted.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int tests = 0;
   int fails = 0;

   wr_t exp_q[$];

   // Reference model state
   bit busy_m[32];
   bit last_was_b;

   writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      last_was_b = 1'b1;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
      bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
      bus.issue_valid = 0; bus.issue_addr = 0;
      bus.inst_read_reg_addr1 = 0; bus.inst_read_reg_addr2 = 0;
   endtask

   // One clock cycle of stimulus, model prediction and combinational checks.
   task automatic drive_cycle(
      input  bit av, input logic [4:0] aa, input logic [31:0] ad,
      input  bit bv, input logic [4:0] ba, input logic [31:0] bd,
      input  bit iv, input logic [4:0] ia,
      input  logic [4:0] r1, input logic [4:0] r2,
      output bit ga, output bit gb);
      bit   exp_stall;
      wr_t  w;
      @(posedge clk);
      #1;
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
      bus.issue_valid = iv; bus.issue_addr = ia;
      bus.inst_read_reg_addr1 = r1; bus.inst_read_reg_addr2 = r2;
      #2;
      // Round robin: alone wins; on a tie the one that did not win last
      ga = av && (!bv || last_was_b);
      gb = bv && (!av || !last_was_b);
      exp_stall = busy_m[r1] || busy_m[r2] || (iv && busy_m[ia]);
      check("a_ready", {31'b0, bus.a_ready}, {31'b0, ga});
      check("b_ready", {31'b0, bus.b_ready}, {31'b0, gb});
      check("stall",   {31'b0, bus.stall},   {31'b0, exp_stall});
      if (ga || gb) begin
         w.addr = ga ? aa : ba;
         w.data = ga ? ad : bd;
         last_was_b = gb;
         if (w.addr != 0) begin
            exp_q.push_back(w);
            busy_m[w.addr] = 1'b0;
         end
      end
      if (iv && !exp_stall && ia != 0) busy_m[ia] = 1'b1;
   endtask

   // Asynchronous reset asserted away from any clock edge
   task automatic mid_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("reset_reg_wr", {31'b0, bus.reg_wr}, 32'd0);
      check("reset_stall",  {31'b0, bus.stall},  32'd0);
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Monitor: one line per register-file write
   always @(negedge clk) begin
      if (bus.reg_wr !== 1'b0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got reg_wr=%b addr=%0d data=%0h required no write",
                     bus.reg_wr, bus.reg_wr_addr, bus.reg_wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            $display("[TB] write r%0d <= %08h (expected r%0d <= %08h)",
                     bus.reg_wr_addr, bus.reg_wr_data, e.addr, e.data);
            check("write_addr", {27'b0, bus.reg_wr_addr}, {27'b0, e.addr});
            check("write_data", bus.reg_wr_data, e.data);
         end
      end
   end

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin : stim
      bit ga, gb;
      bit a_hold, b_hold;
      bit av, bv, iv;
      logic [4:0]  aa, ba, ia, r1, r2;
      logic [31:0] ad, bd;

      idle_inputs();
      model_reset();
      #12;
      check("init_reg_wr", {31'b0, bus.reg_wr}, 32'd0);
      check("init_stall",  {31'b0, bus.stall},  32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Contention right after reset: A first, then strict alternation
      for (int i = 0; i < 4; i++)
         drive_cycle(1, 5'd4, 32'hAAAA_0004, 1, 5'd7, 32'hBBBB_0007, 0, 0, 0, 0, ga, gb);
      // Single ALU write
      drive_cycle(1, 5'd5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // Load to r0 plus issue to r0: accepted, no write, no stall
      drive_cycle(0, 0, 0, 1, 5'd0, 32'h0000_FFFF, 1, 5'd0, 0, 0, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, ga, gb);
      // Scoreboard: issue r15, read r15, ALU clears r15
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 5'd15, 0, 0, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd15, 0, ga, gb);
      drive_cycle(1, 5'd15, 32'hCAFE_000F, 0, 0, 0, 0, 0, 5'd15, 0, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd15, 0, ga, gb);
      // Same-cycle set and clear of r16: set wins
      drive_cycle(0, 0, 0, 1, 5'd16, 32'h1616_1616, 1, 5'd16, 0, 0, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd16, ga, gb);
      drive_cycle(1, 5'd16, 32'h0000_0016, 0, 0, 0, 0, 0, 0, 5'd16, ga, gb);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd16, ga, gb);

      // Randomized traffic; requesters hold until granted
      a_hold = 0; b_hold = 0;
      av = 0; bv = 0; aa = 0; ba = 0; ad = 0; bd = 0;
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            mid_reset();
            a_hold = 0; b_hold = 0;
         end
         if (!a_hold) begin
            av = ($urandom_range(0, 2) != 0);
            aa = rand_addr();
            ad = $urandom;
         end
         if (!b_hold) begin
            bv = ($urandom_range(0, 2) != 0);
            ba = rand_addr();
            bd = $urandom;
         end
         iv = ($urandom_range(0, 1) == 1);
         ia = rand_addr();
         r1 = rand_addr();
         r2 = rand_addr();
         drive_cycle(av, aa, ad, bv, ba, bd, iv, ia, r1, r2, ga, gb);
         a_hold = av && !ga;
         b_hold = bv && !gb;
      end

      // Drain
      for (int i = 0; i < 3; i++)
         drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      @(negedge clk);
      #1;
      check("pending_writes", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
